// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA constants, decoded-instruction struct and decode helpers
//   for the decode stage and its branch history table.
//   decode()    : splits a 16-bit word into opcode, register fields, imm8 and
//                 memory/source-use flags
//   reads_reg() : true when the decoded instruction sources the given register
package isa_pkg;

    localparam logic [3:0] OP_ALU_LAST = 4'h7;
    localparam logic [3:0] OP_LOAD     = 4'h8;
    localparam logic [3:0] OP_STORE    = 4'h9;
    localparam logic [3:0] OP_LI       = 4'hA;
    localparam logic [3:0] OP_NOP      = 4'hB;
    localparam logic [3:0] OP_BEZ      = 4'hC;
    localparam logic [3:0] OP_BNZ      = 4'hD;
    localparam logic [3:0] OP_JMP      = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    // Bit positions of the 4-bit fields: opcode, then fields A/B/C high to low.
    localparam int OPC_LSB   = 12;
    localparam int FLD_A_LSB = 8;
    localparam int FLD_B_LSB = 4;
    localparam int FLD_C_LSB = 0;

    localparam int                   BHT_ENTRIES = 16;
    localparam int                   BHT_IDX_W   = 4;
    localparam int                   BHT_CTR_W   = 2;
    localparam logic [BHT_CTR_W-1:0] BHT_RESET   = 2'b01;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] imm8;
        logic       mem_read;
        logic       mem_write;
        logic       use_rs1;
        logic       use_rs2;
    } dec_t;

    // Fields that an opcode does not use are left at zero so the ID/EX
    // register carries clean values downstream.
    function automatic dec_t decode(input logic [15:0] instr);
        dec_t       d;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        a        = instr[FLD_A_LSB +: 4];
        b        = instr[FLD_B_LSB +: 4];
        c        = instr[FLD_C_LSB +: 4];
        d        = '0;
        d.opcode = instr[OPC_LSB +: 4];
        if (d.opcode <= OP_ALU_LAST) begin
            d.rd      = a;
            d.rs1     = b;
            d.rs2     = c;
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
        end else begin
            case (d.opcode)
                OP_LOAD: begin
                    d.rd       = a;
                    d.rs1      = b;
                    d.use_rs1  = 1'b1;
                    d.mem_read = 1'b1;
                end
                OP_STORE: begin
                    d.rs1       = b;
                    d.rs2       = a;
                    d.use_rs1   = 1'b1;
                    d.use_rs2   = 1'b1;
                    d.mem_write = 1'b1;
                end
                OP_LI: begin
                    d.rd   = a;
                    d.imm8 = instr[7:0];
                end
                OP_BEZ, OP_BNZ: begin
                    d.rs1     = a;
                    d.use_rs1 = 1'b1;
                    d.imm8    = instr[7:0];
                end
                default: ;
            endcase
        end
        return d;
    endfunction

    function automatic logic reads_reg(input dec_t d, input logic [3:0] r);
        return (d.use_rs1 && d.rs1 == r) || (d.use_rs2 && d.rs2 == r);
    endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: table of 2-bit saturating taken/not-taken counters.
//   clk, reset (async, active low) : all counters return to BHT_RESET
//   lookup_idx  -> lookup_taken     : counter MSB, read combinationally
//   update_en, update_idx, update_taken : train one counter per cycle
// A lookup of the index being updated in the same cycle sees the old value.
module branch_predictor_bht
    import isa_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BHT_IDX_W-1:0] lookup_idx,
    output logic                 lookup_taken,
    input  logic                 update_en,
    input  logic [BHT_IDX_W-1:0] update_idx,
    input  logic                 update_taken
);

    localparam logic [BHT_CTR_W-1:0] CTR_MAX = '1;

    logic [BHT_CTR_W-1:0] ctr [BHT_ENTRIES];
    logic [BHT_CTR_W-1:0] cur;
    logic [BHT_CTR_W-1:0] nxt;

    assign cur          = ctr[update_idx];
    assign nxt          = update_taken ? ((cur == CTR_MAX) ? cur : cur + 1'b1)
                                       : ((cur == '0)      ? cur : cur - 1'b1);
    assign lookup_taken = ctr[lookup_idx][BHT_CTR_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= BHT_RESET;
        end else if (update_en) begin
            ctr[update_idx] <= nxt;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with IF/ID hold, ID/EX register, load-use
//   interlock, HALT latching and BHT-based static-target branch prediction.
//   clk, reset (async, active low)
//   instruction, pc_in, valid_in             : from fetch
//   ex_resolve, ex_taken, ex_pc              : branch outcome for BHT training
//   ex_mispredict, ex_redirect               : execute-side recovery request
//   stall, flush, PC_sel, predict_taken, halt, branch_target : fetch controls
//                                              (combinational)
//   id_*                                     : ID/EX register (1-cycle latency)
module decode_stage
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [7:0]  pc_in,
    input  logic        valid_in,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    input  logic [7:0]  ex_pc,
    input  logic        ex_mispredict,
    input  logic [7:0]  ex_redirect,
    output logic        stall,
    output logic        flush,
    output logic        PC_sel,
    output logic        predict_taken,
    output logic        halt,
    output logic [7:0]  branch_target,
    output logic        id_valid,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_pred_taken,
    output logic [3:0]  id_opcode,
    output logic [3:0]  id_rd,
    output logic [3:0]  id_rs1,
    output logic [3:0]  id_rs2,
    output logic [7:0]  id_imm8,
    output logic [7:0]  id_pc
);

    dec_t dec;
    logic stall_q;
    logic hold_valid_q;
    logic halt_q;
    logic ev;
    logic live;
    logic is_branch;
    logic bht_taken;
    logic halt_now;
    logic load_use;
    logic issue;
    logic unused_ex_pc_hi;

    assign unused_ex_pc_hi = ^ex_pc[7:BHT_IDX_W];

    assign dec = decode(instruction);

    // Fetch drops valid_in while stalled but keeps presenting the word, so the
    // validity of a held instruction comes from our own register.
    assign ev   = stall_q ? hold_valid_q : valid_in;
    // Once halted nothing else may issue or steer fetch.
    assign live = ev & ~halt_q;

    assign is_branch = (dec.opcode == OP_BEZ) || (dec.opcode == OP_BNZ);

    // Each term excludes every higher-priority condition so exactly one of
    // mispredict / halt / load-use / predict acts in a cycle.
    assign halt_now      = ~ex_mispredict & live & (dec.opcode == OP_HALT);
    assign load_use      = live & id_valid & id_mem_read & reads_reg(dec, id_rd);
    assign stall         = ~ex_mispredict & ~halt_now & load_use;
    assign predict_taken = ~ex_mispredict & ~halt_now & ~load_use & live & is_branch & bht_taken;
    assign issue         = ~ex_mispredict & ~stall & live;

    assign PC_sel        = ex_mispredict;
    assign flush         = ex_mispredict | halt_now | predict_taken;
    assign halt          = halt_q | halt_now;
    assign branch_target = ex_mispredict ? ex_redirect
                         : predict_taken ? dec.imm8
                         : 8'h00;

    branch_predictor_bht u_bht (
        .clk          (clk),
        .reset        (reset),
        .lookup_idx   (pc_in[BHT_IDX_W-1:0]),
        .lookup_taken (bht_taken),
        .update_en    (ex_resolve),
        .update_idx   (ex_pc[BHT_IDX_W-1:0]),
        .update_taken (ex_taken)
    );

    // Bubbles clear every ID/EX field, not just id_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q       <= 1'b0;
            hold_valid_q  <= 1'b0;
            halt_q        <= 1'b0;
            id_valid      <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_pred_taken <= 1'b0;
            id_opcode     <= 4'h0;
            id_rd         <= 4'h0;
            id_rs1        <= 4'h0;
            id_rs2        <= 4'h0;
            id_imm8       <= 8'h00;
            id_pc         <= 8'h00;
        end else begin
            stall_q       <= stall;
            hold_valid_q  <= stall & ev;
            halt_q        <= halt_q | halt_now;
            id_valid      <= issue;
            id_mem_read   <= issue & dec.mem_read;
            id_mem_write  <= issue & dec.mem_write;
            id_pred_taken <= issue & predict_taken;
            id_opcode     <= issue ? dec.opcode : 4'h0;
            id_rd         <= issue ? dec.rd     : 4'h0;
            id_rs1        <= issue ? dec.rs1    : 4'h0;
            id_rs2        <= issue ? dec.rs2    : 4'h0;
            id_imm8       <= issue ? dec.imm8   : 8'h00;
            id_pc         <= issue ? pc_in      : 8'h00;
        end
    end

endmodule
